// File: rtl/norm_lead_one_pipe.sv
// norm_lead_one_pipe
//   Two-stage leading-one detector and mantissa normaliser that sits between
//   the mantissa multiplier/adder and the exponent-adjust/round stage.
//
//   S1 (detect): priority-encodes the highest set bit of in_data and registers
//                the data, the mode bit, the position and a zero flag.
//   S2 (shift) : computes the leading-zero count and left-justifies the
//                mantissa, keeping or dropping the leading (hidden) one.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_keep valid this cycle
//   in_ready   block accepts input this cycle
//   in_data    unnormalised mantissa, WIDTH bits
//   in_keep    1 = keep leading one at MSB, 0 = drop hidden bit
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   normalised mantissa, WIDTH bits
//   out_pos    bit index of the leading one (0 for zero input)
//   out_lzc    leading-zero count (WIDTH for zero input)
//   out_zero   input was all zeros
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Producers hold valid and payload stable until the transfer;
// in_ready is a function of registered pipeline state and out_ready only,
// never of in_valid, so there is no combinational valid->ready loop.

module norm_lead_one_pipe #(
    parameter int WIDTH = 64,
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_keep,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [POS_W-1:0] out_pos,
    output logic [POS_W-1:0] out_lzc,
    output logic             out_zero
);

    // One extra bit so that lzc+1 (up to WIDTH+1) cannot wrap.
    localparam int SH_W = POS_W + 1;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_keep;
    logic [POS_W-1:0] s1_pos;
    logic             s1_zero;

    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;

    // ------------------------------------------------------------------
    // Flow control: each stage advances when it is empty or the stage
    // after it is advancing, so bubbles collapse and throughput is 1/cycle.
    // ------------------------------------------------------------------
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // S1 combinational: priority encoder. Scanning upward means the last
    // set bit seen (the highest one) wins.
    // ------------------------------------------------------------------
    logic [POS_W-1:0] det_pos;
    logic             det_zero;

    always_comb begin
        det_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data[i]) begin
                det_pos = POS_W'(i);
            end
        end
    end

    assign det_zero = (in_data == '0);

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_keep  <= 1'b0;
            s1_pos   <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_keep <= in_keep;
                s1_pos  <= det_pos;
                s1_zero <= det_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: leading-zero count and normalising shift.
    // Dropping the hidden bit is one extra position of left shift; any
    // shift of WIDTH or more (zero input, or pos=0 with the hidden bit
    // dropped) produces an all-zero mantissa.
    // ------------------------------------------------------------------
    logic [POS_W-1:0] s1_lzc;
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH-1:0] sh_data;

    always_comb begin
        s1_lzc  = s1_zero ? POS_W'(WIDTH) : (POS_W'(WIDTH - 1) - s1_pos);
        sh_amt  = {1'b0, s1_lzc} + SH_W'(!s1_keep);
        sh_data = '0;
        if (sh_amt < SH_W'(WIDTH)) begin
            sh_data = s1_data << sh_amt;
        end
    end

    // ------------------------------------------------------------------
    // S2 register (drives the outputs directly). Output fields only load
    // when a valid transaction moves in, so they hold during a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_pos  <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sh_data;
                out_pos  <= s1_pos;
                out_lzc  <= s1_lzc;
                out_zero <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_norm_lead_one_pipe.sv
// Testbench for norm_lead_one_pipe: a WIDTH=64 instance for the directed,
// backpressure and mid-stream reset steps and a WIDTH=24 instance for the
// sweep. Results are checked in order against an expected queue per instance.

module tb_norm_lead_one_pipe;

    logic clk;
    logic rst_n;

    // WIDTH = 64 instance
    logic        i64_valid;
    logic        i64_ready;
    logic [63:0] i64_data;
    logic        i64_keep;
    logic        o64_valid;
    logic        o64_ready;
    logic [63:0] o64_data;
    logic [7:0]  o64_pos;
    logic [7:0]  o64_lzc;
    logic        o64_zero;

    // WIDTH = 24 instance
    logic        i24_valid;
    logic        i24_ready;
    logic [23:0] i24_data;
    logic        i24_keep;
    logic        o24_valid;
    logic        o24_ready;
    logic [23:0] o24_data;
    logic [4:0]  o24_pos;
    logic [4:0]  o24_lzc;
    logic        o24_zero;

    // Expected entries are {data, pos, lzc, zero}
    logic [80:0] exp_q64[$];
    logic [34:0] exp_q24[$];
    logic [80:0] mon_e64;
    logic [34:0] mon_e24;

    int n_cmp = 0;
    int n_err = 0;

    bit tog64 = 0;
    bit tog24 = 0;

    norm_lead_one_pipe #(.WIDTH(64), .POS_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i64_valid), .in_ready(i64_ready),
        .in_data(i64_data), .in_keep(i64_keep),
        .out_valid(o64_valid), .out_ready(o64_ready),
        .out_data(o64_data), .out_pos(o64_pos),
        .out_lzc(o64_lzc), .out_zero(o64_zero)
    );

    norm_lead_one_pipe #(.WIDTH(24), .POS_W(5)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i24_valid), .in_ready(i24_ready),
        .in_data(i24_data), .in_keep(i24_keep),
        .out_valid(o24_valid), .out_ready(o24_ready),
        .out_data(o24_data), .out_pos(o24_pos),
        .out_lzc(o24_lzc), .out_zero(o24_zero)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: walks the mantissa left one bit at a time until the
    // MSB is set, counting steps; the position is found by a separate scan.
    // ------------------------------------------------------------------
    function automatic void model(input logic [127:0] d, input int w, input bit keep,
                                  output logic [127:0] nd, output int pos,
                                  output int lzc, output bit zero);
        logic [127:0] x;
        logic [127:0] mask;
        mask = (128'd1 << w) - 128'd1;
        zero = (d == 128'd0);
        pos  = 0;
        lzc  = w;
        nd   = 128'd0;
        if (!zero) begin
            for (int i = w - 1; i >= 0; i--) begin
                if (d[i]) begin
                    pos = i;
                    break;
                end
            end
            x   = d;
            lzc = 0;
            while (x[w-1] == 1'b0) begin
                x = x << 1;
                lzc++;
            end
            if (!keep) x = x << 1;
            nd = x & mask;
        end
    endfunction

    function automatic logic [80:0] m64(input logic [63:0] d, input bit k);
        logic [127:0] nd;
        int p, l;
        bit z;
        model({64'd0, d}, 64, k, nd, p, l, z);
        return {nd[63:0], 8'(p), 8'(l), z};
    endfunction

    function automatic logic [34:0] m24(input logic [23:0] d, input bit k);
        logic [127:0] nd;
        int p, l;
        bit z;
        model({104'd0, d}, 24, k, nd, p, l, z);
        return {nd[23:0], 5'(p), 5'(l), z};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks: called at posedge+1, return at posedge+1 after the
    // input transfer; in_valid is left high for back-to-back streaming.
    // ------------------------------------------------------------------
    task automatic drive64(input logic [63:0] d, input logic k, input logic [80:0] e);
        bit acc;
        acc = 0;
        i64_data  = d;
        i64_keep  = k;
        i64_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (i64_ready) begin
                acc = 1;
                break;
            end
        end
        chk("d64_accept", 128'(acc), 128'd1);
        if (acc) exp_q64.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive24(input logic [23:0] d, input logic k, input logic [34:0] e);
        bit acc;
        acc = 0;
        i24_data  = d;
        i24_keep  = k;
        i24_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (i24_ready) begin
                acc = 1;
                break;
            end
        end
        chk("d24_accept", 128'(acc), 128'd1);
        if (acc) exp_q24.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain64(input string tag);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q64.size() == 0) break;
        end
        chk(tag, 128'(exp_q64.size()), 128'd0);
    endtask

    task automatic drain24(input string tag);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q24.size() == 0) break;
        end
        chk(tag, 128'(exp_q24.size()), 128'd0);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: every output transfer must match the head of the queue.
    // An output with an empty queue compares against X and is reported.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (o64_valid && o64_ready) begin
            mon_e64 = (exp_q64.size() != 0) ? exp_q64.pop_front() : 'x;
            chk("d64_result", 128'({o64_data, o64_pos, o64_lzc, o64_zero}), 128'(mon_e64));
        end
        if (o24_valid && o24_ready) begin
            mon_e24 = (exp_q24.size() != 0) ? exp_q24.pop_front() : 'x;
            chk("d24_result", 128'({o24_data, o24_pos, o24_lzc, o24_zero}), 128'(mon_e24));
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [63:0] words[10];
    logic        keeps[10];
    logic [23:0] d24v;
    logic        k24v;

    initial begin
        rst_n     = 1'b0;
        i64_valid = 1'b0; i64_data = '0; i64_keep = 1'b0; o64_ready = 1'b1;
        i24_valid = 1'b0; i24_data = '0; i24_keep = 1'b0; o24_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_o64_valid", 128'(o64_valid), 128'd0);
        chk("rst_o64_fields", 128'({o64_data, o64_pos, o64_lzc, o64_zero}), 128'd0);
        chk("rst_o24_valid", 128'(o24_valid), 128'd0);
        chk("rst_o24_fields", 128'({o24_data, o24_pos, o24_lzc, o24_zero}), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in64_ready", 128'(i64_ready), 128'd1);
        chk("rst_in24_ready", 128'(i24_ready), 128'd1);

        // Single transaction and latency: valid appears on the second edge
        drive64(64'h5, 1'b0, {64'h4000_0000_0000_0000, 8'd2, 8'd61, 1'b0});
        i64_valid = 1'b0;
        @(negedge clk);
        chk("lat_one_edge", 128'(o64_valid), 128'd0);
        @(negedge clk);
        chk("lat_two_edges", 128'(o64_valid), 128'd1);
        @(posedge clk);
        #1;

        // Keep mode and boundaries
        drive64(64'h5, 1'b1, {64'hA000_0000_0000_0000, 8'd2, 8'd61, 1'b0});
        drive64(64'h0, 1'b0, {64'h0, 8'd0, 8'd64, 1'b1});
        drive64(64'h0, 1'b1, {64'h0, 8'd0, 8'd64, 1'b1});
        drive64(64'h1, 1'b0, {64'h0, 8'd0, 8'd63, 1'b0});
        drive64(64'h1, 1'b1, {64'h8000_0000_0000_0000, 8'd0, 8'd63, 1'b0});
        drive64(64'h8000_0000_0000_0001, 1'b0, {64'h0000_0000_0000_0002, 8'd63, 8'd0, 1'b0});
        drive64(64'h8000_0000_0000_0001, 1'b1, {64'h8000_0000_0000_0001, 8'd63, 8'd0, 1'b0});
        drive64(64'h0000_0F00_0000_0000, 1'b0, {64'hE000_0000_0000_0000, 8'd43, 8'd20, 1'b0});
        i64_valid = 1'b0;
        drain64("drain_directed");
        @(posedge clk);
        #1;

        // Backpressure: two words fill the pipe, then in_ready drops
        for (int i = 0; i < 10; i++) begin
            words[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
            keeps[i] = 1'($urandom_range(0, 1));
        end
        o64_ready = 1'b0;
        drive64(words[0], keeps[0], m64(words[0], keeps[0]));
        drive64(words[1], keeps[1], m64(words[1], keeps[1]));
        i64_data  = words[2];
        i64_keep  = keeps[2];
        i64_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 128'(i64_ready), 128'd0);
            chk("stall_out_valid", 128'(o64_valid), 128'd1);
            chk("stall_hold", 128'({o64_data, o64_pos, o64_lzc, o64_zero}),
                128'(m64(words[0], keeps[0])));
        end
        @(posedge clk);
        #1;
        tog64 = 1;
        fork
            begin
                while (tog64) begin
                    @(posedge clk);
                    #1;
                    if (tog64) o64_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 2; i < 10; i++) begin
            drive64(words[i], keeps[i], m64(words[i], keeps[i]));
        end
        i64_valid = 1'b0;
        tog64 = 0;
        @(posedge clk);
        #1;
        o64_ready = 1'b1;
        drain64("drain_backpressure");

        // Reset with both stages full: out_valid falls without a clock edge
        @(posedge clk);
        #1;
        o64_ready = 1'b0;
        drive64(64'h0000_0000_1234_5678, 1'b1, m64(64'h0000_0000_1234_5678, 1'b1));
        drive64(64'h0000_0000_0000_00FF, 1'b0, m64(64'h0000_0000_0000_00FF, 1'b0));
        i64_valid = 1'b0;
        #1;
        chk("pre_reset_full", 128'({o64_valid, i64_ready}), 128'b10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(o64_valid), 128'd0);
        chk("async_rst_fields", 128'({o64_data, o64_pos, o64_lzc, o64_zero}), 128'd0);
        exp_q64.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        o64_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 128'(o64_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        drive64(64'h0000_0000_0000_0100, 1'b1, {64'h8000_0000_0000_0000, 8'd8, 8'd55, 1'b0});
        i64_valid = 1'b0;
        drain64("drain_after_reset");

        // WIDTH = 24 directed points
        @(posedge clk);
        #1;
        drive24(24'h000800, 1'b1, {24'h800000, 5'd11, 5'd12, 1'b0});
        drive24(24'h000800, 1'b0, {24'h000000, 5'd11, 5'd12, 1'b0});
        drive24(24'h000000, 1'b1, {24'h000000, 5'd0, 5'd24, 1'b1});
        drive24(24'h800001, 1'b0, {24'h000002, 5'd23, 5'd0, 1'b0});
        drive24(24'h000003, 1'b0, {24'h800000, 5'd1, 5'd22, 1'b0});

        // WIDTH = 24 sweep with random backpressure
        tog24 = 1;
        fork
            begin
                while (tog24) begin
                    @(posedge clk);
                    #1;
                    if (tog24) o24_ready = 1'($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            d24v = (i % 50 == 0) ? 24'd0 : (24'($urandom) >> $urandom_range(0, 23));
            k24v = 1'($urandom_range(0, 1));
            drive24(d24v, k24v, m24(d24v, k24v));
        end
        i24_valid = 1'b0;
        tog24 = 0;
        @(posedge clk);
        #1;
        o24_ready = 1'b1;
        drain24("drain_sweep24");

        repeat (3) @(negedge clk);
        chk("final_q64_empty", 128'(exp_q64.size()), 128'd0);
        chk("final_q24_empty", 128'(exp_q24.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
